uart_tx_fifo: RTL

//   Transmit-side word buffer directly upstream of uart_tx. Accepts words from the
//   bus/register side on a valid/ready push port, stores up to DEPTH of them, and

---
 rtl/uart_pkg.sv | 21 ++
 rtl/fifo_ram.sv | 30 +++
 rtl/uart_tx_fifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths/depths and the FIFO status record
// consumed by the register block.
package uart_pkg;

   localparam int unsigned UART_WORD_WIDTH    = 8;
   localparam int unsigned UART_TX_FIFO_DEPTH = 16;
   localparam int unsigned UART_FIFO_LW       = $clog2(UART_TX_FIFO_DEPTH + 1);

   typedef struct packed {
      logic [UART_FIFO_LW-1:0] level;
      logic                    empty;
      logic                    full;
      logic                    overflow_err;
   } uart_fifo_status_t;

   // True when v is a non-zero power of two.
   function automatic bit uart_is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the UART FIFOs: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fifo_ram #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the word on the rising edge when enabled.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: combinational, gives first-word-fall-through at the top level.
   always_comb begin
      o_rdata = mem[i_raddr];
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side word buffer feeding uart_tx. Valid/ready push port in,
// first-word-fall-through valid/ready port out, sticky overflow flag.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = UART_WORD_WIDTH,
   parameter int unsigned DEPTH      = UART_TX_FIFO_DEPTH,
   localparam int unsigned LW        = $clog2(DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic [WORD_WIDTH-1:0] i_push_data,
   input  logic                  i_push_valid,
   output logic                  o_push_ready,
   output logic [WORD_WIDTH-1:0] o_wr_data,
   output logic                  o_wr_valid,
   input  logic                  i_wr_ready,
   output logic [LW-1:0]         o_level,
   output logic                  o_empty,
   output logic                  o_full,
   output logic                  o_overflow_err,
   input  logic                  i_err_clear
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   if (!uart_is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic          empty, full;
   logic          push, pop, overflow_set;

   // Flags from the pointers; the extra MSB distinguishes full from empty.
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   end

   // Handshake decode; flush overrides both ports and suppresses overflow.
   always_comb begin
      push         = i_push_valid && !full && !i_flush;
      pop          = !empty && i_wr_ready && !i_flush;
      overflow_set = i_push_valid && full && !i_flush;
   end

   // Next-state for pointers, level and the sticky error.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (i_flush) begin
         rd_ptr_d = wr_ptr_q;
         level_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            level_d = level_q + LW'(1);
         end else if (pop && !push) begin
            level_d = level_q - LW'(1);
         end
      end

      // Set wins over clear when both happen in one cycle.
      if (overflow_set) begin
         overflow_d = 1'b1;
      end else if (i_err_clear) begin
         overflow_d = 1'b0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   fifo_ram #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (push),
      .i_waddr (wr_ptr_q[AW-1:0]),
      .i_wdata (i_push_data),
      .i_raddr (rd_ptr_q[AW-1:0]),
      .o_rdata (o_wr_data)
   );

   // Output drive.
   always_comb begin
      o_empty        = empty;
      o_full         = full;
      o_push_ready   = !full;
      o_wr_valid     = !empty;
      o_level        = level_q;
      o_overflow_err = overflow_q;
   end

endmodule
